// File: rtl/opo_package.sv
// Shared widths, FSM state type and constants for the sync demodulator.
package opo_package;

    localparam int unsigned word_width         = 16;
    localparam int unsigned config_reg_width   = 16;
    localparam int unsigned DEMOD_FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } demod_state_t;

endpackage

// File: rtl/sat_accumulator.sv
// Signed accumulator with synchronous clear, enable and sticky saturation.
module sat_accumulator #(
    parameter int unsigned ACC_WIDTH = 48,
    parameter int unsigned IN_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        en,
    input  logic signed [IN_WIDTH-1:0]  addend,
    output logic signed [ACC_WIDTH-1:0] acc
);

    localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_c;
    logic                      saturated;

    // One guard bit is enough: both operands lie inside the ACC_WIDTH range.
    always_comb begin
        sum_c = {acc[ACC_WIDTH-1], acc} + (ACC_WIDTH+1)'(addend);
    end

    // Accumulate; once a bound is hit the sum is frozen until the next clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            saturated <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            saturated <= 1'b0;
        end else if (en && !saturated) begin
            if (sum_c > ACC_MAX) begin
                acc       <= ACC_MAX[ACC_WIDTH-1:0];
                saturated <= 1'b1;
            end else if (sum_c < ACC_MIN) begin
                acc       <= ACC_MIN[ACC_WIDTH-1:0];
                saturated <= 1'b1;
            end else begin
                acc <= sum_c[ACC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/sync_demod_accumulator.sv
// Lock-in style I/Q demodulator: multiplies samples by sin/cos references and
// integrates over a programmed number of valid samples.
// Optional feature macro: SYNC_DEMOD_PEAK_DETECT_EN (peak_max/peak_min tracking).
module sync_demod_accumulator
    import opo_package::*;
#(
    parameter int unsigned ACC_WIDTH = 48
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic        [config_reg_width-1:0] num_samples,
    input  logic signed [word_width-1:0]       sample_in,
    input  logic                               sample_in_valid,
    input  logic signed [word_width-1:0]       ref_sin,
    input  logic signed [word_width-1:0]       ref_cos,
    output logic signed [ACC_WIDTH-1:0]        i_out,
    output logic signed [ACC_WIDTH-1:0]        q_out,
    output logic                               result_valid,
    output logic                               busy,
    output logic signed [word_width-1:0]       peak_max,
    output logic signed [word_width-1:0]       peak_min
);

    localparam int unsigned PROD_WIDTH  = 2 * word_width;
    localparam int unsigned FLUSH_WIDTH = $clog2(DEMOD_FLUSH_CYCLES + 1);

    demod_state_t                    state;
    logic [config_reg_width-1:0]     count;
    logic [config_reg_width-1:0]     target;
    logic [FLUSH_WIDTH-1:0]          flush_count;
    logic signed [PROD_WIDTH-1:0]    prod_sin;
    logic signed [PROD_WIDTH-1:0]    prod_cos;
    logic                            prod_valid;
    logic signed [ACC_WIDTH-1:0]     acc_i;
    logic signed [ACC_WIDTH-1:0]     acc_q;
    logic                            start_ok_c;
    logic                            accept_c;

    // Start only counts in IDLE once the previous result cycle has passed.
    always_comb begin
        start_ok_c = start && !busy && (state == IDLE);
        accept_c   = sample_in_valid && (state == INTEG);
    end

    // Measurement sequencer with registered busy/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            target       <= '0;
            flush_count  <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            i_out        <= '0;
            q_out        <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok_c) begin
                        target <= num_samples;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= (num_samples == '0) ? DONE : INTEG;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                INTEG: begin
                    if (sample_in_valid) begin
                        count <= count + config_reg_width'(1);
                        if (count == target - config_reg_width'(1)) begin
                            flush_count <= '0;
                            state       <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    flush_count <= flush_count + FLUSH_WIDTH'(1);
                    if (flush_count == FLUSH_WIDTH'(DEMOD_FLUSH_CYCLES - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    i_out        <= acc_i;
                    q_out        <= acc_q;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Product stage: one register of sample*reference per accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_sin   <= '0;
            prod_cos   <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= accept_c;
            if (accept_c) begin
                prod_sin <= sample_in * ref_sin;
                prod_cos <= sample_in * ref_cos;
            end
        end
    end

    sat_accumulator #(
        .ACC_WIDTH (ACC_WIDTH),
        .IN_WIDTH  (PROD_WIDTH)
    ) u_acc_i (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_ok_c),
        .en     (prod_valid),
        .addend (prod_sin),
        .acc    (acc_i)
    );

    sat_accumulator #(
        .ACC_WIDTH (ACC_WIDTH),
        .IN_WIDTH  (PROD_WIDTH)
    ) u_acc_q (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_ok_c),
        .en     (prod_valid),
        .addend (prod_cos),
        .acc    (acc_q)
    );

`ifdef SYNC_DEMOD_PEAK_DETECT_EN
    localparam logic signed [word_width-1:0] WORD_MIN = {1'b1, {(word_width-1){1'b0}}};
    localparam logic signed [word_width-1:0] WORD_MAX = {1'b0, {(word_width-1){1'b1}}};

    logic signed [word_width-1:0] track_max;
    logic signed [word_width-1:0] track_min;

    // Track extremes of accepted samples; publish them with the I/Q result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            track_max <= '0;
            track_min <= '0;
            peak_max  <= '0;
            peak_min  <= '0;
        end else begin
            if (start_ok_c) begin
                track_max <= WORD_MIN;
                track_min <= WORD_MAX;
            end else if (accept_c) begin
                if (sample_in > track_max) track_max <= sample_in;
                if (sample_in < track_min) track_min <= sample_in;
            end
            if (state == DONE) begin
                peak_max <= track_max;
                peak_min <= track_min;
            end
        end
    end
`else
    assign peak_max = '0;
    assign peak_min = '0;
`endif

endmodule

// File: tb/tb_sync_demod_accumulator.sv
// Scoreboard bench for sync_demod_accumulator with a behavioural I/Q model.
module tb_sync_demod_accumulator;
    import opo_package::*;

    typedef struct {
        longint i;
        longint q;
        int     pmax;
        int     pmin;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    int   sq[$];

    // main DUT (48-bit accumulators)
    logic                               start = 1'b0;
    logic        [config_reg_width-1:0] num_samples = '0;
    logic signed [word_width-1:0]       sample_in = '0;
    logic                               sample_in_valid = 1'b0;
    logic signed [word_width-1:0]       ref_sin = '0;
    logic signed [word_width-1:0]       ref_cos = '0;
    logic signed [47:0]                 i_out, q_out;
    logic                               result_valid, busy;
    logic signed [word_width-1:0]       peak_max, peak_min;

    // narrow DUT (33-bit accumulators) for saturation
    logic                               s_start = 1'b0;
    logic        [config_reg_width-1:0] s_num = '0;
    logic signed [word_width-1:0]       s_sample = '0;
    logic                               s_valid = 1'b0;
    logic signed [word_width-1:0]       s_sin = '0;
    logic signed [word_width-1:0]       s_cos = '0;
    logic signed [32:0]                 s_i, s_q;
    logic                               s_rv, s_busy;
    logic signed [word_width-1:0]       s_pmax, s_pmin;

    sync_demod_accumulator #(.ACC_WIDTH(48)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid),
        .ref_sin(ref_sin), .ref_cos(ref_cos), .i_out(i_out), .q_out(q_out),
        .result_valid(result_valid), .busy(busy),
        .peak_max(peak_max), .peak_min(peak_min)
    );

    sync_demod_accumulator #(.ACC_WIDTH(33)) dut33 (
        .clk(clk), .rst(rst), .start(s_start), .num_samples(s_num),
        .sample_in(s_sample), .sample_in_valid(s_valid),
        .ref_sin(s_sin), .ref_cos(s_cos), .i_out(s_i), .q_out(s_q),
        .result_valid(s_rv), .busy(s_busy),
        .peak_max(s_pmax), .peak_min(s_pmin)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    endtask

    // Saturating running sum with sticky bound, ACC bits wide.
    function automatic void acc_step(inout longint a, inout bit sat, input longint p, input int aw);
        longint hi, lo;
        hi = (longint'(1) <<< (aw - 1)) - 1;
        lo = -(longint'(1) <<< (aw - 1));
        if (!sat) begin
            a = a + p;
            if (a > hi) begin a = hi; sat = 1'b1; end
            else if (a < lo) begin a = lo; sat = 1'b1; end
        end
    endfunction

    // Monitor: every result pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("i_out", i_out, e.i);
                chk("q_out", q_out, e.q);
                chk("result_cycle", cyc, e.cyc);
                chk("peak_max", peak_max, e.pmax);
                chk("peak_min", peak_min, e.pmin);
                chk("busy_at_result", busy, 1);
            end
        end
    end

    // gap_mode: 0 every cycle, 1 every other cycle, 2 random gaps.
    // mode: 0 random data, 1 fixed 1000/2000/-500, 2 samples from sq.
    task automatic run_meas(input int n, input int gap_mode, input int mode, input bit repulse);
        exp_t e;
        bit sat_i = 1'b0, sat_q = 1'b0, v, alt = 1'b1;
        int k = 0, last = 0;
        logic signed [15:0] s, rs, rc;
        e.i = 0; e.q = 0; e.pmax = -32768; e.pmin = 32767; e.cyc = 0;
        start = 1'b1; num_samples = 16'(n); sample_in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) e.cyc = cyc + 1;
        while (k < n) begin
            case (gap_mode)
                0: v = 1'b1;
                1: begin v = alt; alt = ~alt; end
                default: v = ($urandom_range(0, 99) >= 30);
            endcase
            start = repulse && (k == n / 2);
            if (v) begin
                case (mode)
                    1: begin s = 16'sd1000; rs = 16'sd2000; rc = -16'sd500; end
                    2: begin s = 16'(sq[k]); rs = 16'($urandom); rc = 16'($urandom); end
                    default: begin s = 16'($urandom); rs = 16'($urandom); rc = 16'($urandom); end
                endcase
                acc_step(e.i, sat_i, longint'(s) * longint'(rs), 48);
                acc_step(e.q, sat_q, longint'(s) * longint'(rc), 48);
                if (int'(s) > e.pmax) e.pmax = int'(s);
                if (int'(s) < e.pmin) e.pmin = int'(s);
                last = cyc + 1;
                k++;
            end else begin
                s = 16'h7FFF; rs = 16'h7FFF; rc = 16'h7FFF;
            end
            sample_in = s; ref_sin = rs; ref_cos = rc; sample_in_valid = v;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (n > 0) e.cyc = last + 3;
`ifndef SYNC_DEMOD_PEAK_DETECT_EN
        e.pmax = 0; e.pmin = 0;
`endif
        sb.push_back(e);
        // valid data after the last sample must be ignored
        sample_in_valid = 1'b1;
        repeat (3) begin
            sample_in = 16'($urandom); ref_sin = 16'($urandom); ref_cos = 16'($urandom);
            @(posedge clk); #1;
        end
        sample_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_reached", longint'(t < 200), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_out", i_out, 0);
        chk("rst_q_out", q_out, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_peak_max", peak_max, 0);
        chk("rst_peak_min", peak_min, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_meas(4, 0, 1, 1'b0);
        wait_idle();
        chk("tp_const_i", i_out, 64'sd8000000);
        chk("tp_const_q", q_out, -64'sd2000000);
        chk("busy_after_result", busy, 0);

        run_meas(4, 1, 1, 1'b0);
        wait_idle();
        run_meas(0, 0, 0, 1'b0);
        wait_idle();
        chk("zero_n_i", i_out, 0);

        for (int r = 0; r < 6; r++) begin
            run_meas($urandom_range(1, 20), (r % 2 == 0) ? 2 : 0, 0, r[1]);
            wait_idle();
        end

        sq = '{5, -7, 3, 12};
        run_meas(4, 2, 2, 1'b0);
        wait_idle();

        // abort mid-integration
        start = 1'b1; num_samples = 16'd10;
        @(posedge clk); #1;
        start = 1'b0; sample_in_valid = 1'b1;
        repeat (3) begin
            sample_in = 16'($urandom); ref_sin = 16'($urandom); ref_cos = 16'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; sample_in_valid = 1'b0;
        #1;
        chk("abort_i_out", i_out, 0);
        chk("abort_q_out", q_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result_valid", result_valid, 0);
        chk("abort_peak_max", peak_max, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_meas(7, 2, 0, 1'b0);
        wait_idle();

        // saturation on the 33-bit instance, including a late opposite-sign product
        begin
            longint ei = 0, eq = 0;
            bit si = 1'b0, sqf = 1'b0;
            int t = 0;
            s_start = 1'b1; s_num = 16'd9;
            @(posedge clk); #1;
            s_start = 1'b0;
            for (int k = 0; k < 9; k++) begin
                s_sample = (k < 8) ? -16'sd32768 : 16'sd32767;
                s_sin = -16'sd32768; s_cos = 16'sd32767; s_valid = 1'b1;
                acc_step(ei, si, longint'(s_sample) * longint'(s_sin), 33);
                acc_step(eq, sqf, longint'(s_sample) * longint'(s_cos), 33);
                @(posedge clk); #1;
            end
            s_valid = 1'b0;
            while (!s_rv && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("sat_result_seen", longint'(s_rv), 1);
            chk("sat_i_max", s_i, ei);
            chk("sat_q_min", s_q, eq);
            chk("sat_i_const", s_i, 64'sd4294967295);
`ifdef SYNC_DEMOD_PEAK_DETECT_EN
            chk("sat_peak_max", s_pmax, 32767);
            chk("sat_peak_min", s_pmin, -32768);
`else
            chk("sat_peak_max", s_pmax, 0);
            chk("sat_peak_min", s_pmin, 0);
`endif
            @(posedge clk); #1;
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
